// File: rtl/servo_pwm_ramp.sv
// Servo PWM generator with a slew-limited angle ramp that advances once per PWM frame.
// The pulse width follows the commanded angle one frame late, through a serial divider.
module servo_pwm_ramp #(
  parameter int unsigned PERIOD_CYC = 1_000_000,
  parameter int unsigned MIN_PULSE  = 25_000,
  parameter int unsigned MAX_PULSE  = 125_000,
  parameter int unsigned ANGLE_MAX  = 180,
  parameter logic [31:0] STEP       = 32'h0002_0000,
  parameter logic [31:0] HOME       = 32'h005A_0000,
  parameter int unsigned HOME_PULSE = 75_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] angle_in,
  input  logic        angle_valid,
  output logic        pwm_out,
  output logic [31:0] cur_angle,
  output logic        at_target,
  output logic        clamped,
  output logic        frame_start,
  output logic        busy
);

  localparam int unsigned CW       = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD_CYC - 1);
  localparam logic [31:0] AMAX_Q   = 32'(ANGLE_MAX) << 5'd16;
  localparam logic [32:0] DEN      = {1'b0, AMAX_Q};
  localparam logic [63:0] SPAN     = 64'(MAX_PULSE - MIN_PULSE);

  logic [CW-1:0] cnt_r;
  logic          frame_start_r;
  logic          pwm_r;
  logic [31:0]   target_r;
  logic [31:0]   cur_r;
  logic          clamped_r;
  logic [31:0]   pw_active_r;
  logic [31:0]   pw_next_r;
  logic          busy_r;
  logic [63:0]   quo_r;
  logic [31:0]   rem_r;
  logic [5:0]    iter_r;

  logic [31:0]   ramp_cur_s;
  logic [32:0]   rem_sh_s;
  logic [31:0]   rem_nxt_s;
  logic          q_bit_s;
  logic [63:0]   quo_nxt_s;
  logic          boundary_s;

  assign boundary_s = (cnt_r == CNT_LAST) && en;

  // Next commanded angle: move toward target by at most STEP.
  always_comb begin
    ramp_cur_s = cur_r;
    if (target_r >= cur_r) begin
      if ((target_r - cur_r) <= STEP) begin
        ramp_cur_s = target_r;
      end else begin
        ramp_cur_s = cur_r + STEP;
      end
    end else begin
      if ((cur_r - target_r) <= STEP) begin
        ramp_cur_s = target_r;
      end else begin
        ramp_cur_s = cur_r - STEP;
      end
    end
  end

  // One restoring-division step; remainder always stays below the divisor.
  always_comb begin
    rem_sh_s = {rem_r, quo_r[63]};
    if (rem_sh_s >= DEN) begin
      q_bit_s   = 1'b1;
      rem_nxt_s = 32'(rem_sh_s - DEN);
    end else begin
      q_bit_s   = 1'b0;
      rem_nxt_s = rem_sh_s[31:0];
    end
    quo_nxt_s = {quo_r[62:0], q_bit_s};
  end

  // Frame counter, frame strobe and registered PWM output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r         <= '0;
      frame_start_r <= 1'b0;
      pwm_r         <= 1'b0;
    end else begin
      cnt_r         <= (cnt_r == CNT_LAST) ? '0 : cnt_r + 1'b1;
      frame_start_r <= (cnt_r == CNT_LAST);
      pwm_r         <= en & (32'(cnt_r) < pw_active_r);
    end
  end

  // Target capture and once-per-frame ramp; the ramp sees the pre-capture target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_r    <= HOME;
      cur_r       <= HOME;
      clamped_r   <= 1'b0;
      pw_active_r <= 32'(HOME_PULSE);
    end else begin
      if (angle_valid) begin
        target_r  <= (angle_in > AMAX_Q) ? AMAX_Q : angle_in;
        clamped_r <= (angle_in > AMAX_Q);
      end else begin
        target_r  <= target_r;
        clamped_r <= clamped_r;
      end
      if (boundary_s) begin
        cur_r       <= ramp_cur_s;
        pw_active_r <= pw_next_r;
      end else begin
        cur_r       <= cur_r;
        pw_active_r <= pw_active_r;
      end
    end
  end

  // Pulse-width divider: launched at cnt==0, 64 cycles, result loaded as busy drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r    <= 1'b0;
      quo_r     <= 64'd0;
      rem_r     <= 32'd0;
      iter_r    <= 6'd0;
      pw_next_r <= 32'(HOME_PULSE);
    end else if (busy_r) begin
      quo_r  <= quo_nxt_s;
      rem_r  <= rem_nxt_s;
      iter_r <= iter_r + 6'd1;
      if (iter_r == 6'd63) begin
        busy_r    <= 1'b0;
        pw_next_r <= 32'(MIN_PULSE) + quo_nxt_s[31:0];
      end else begin
        busy_r    <= 1'b1;
        pw_next_r <= pw_next_r;
      end
    end else if (cnt_r == '0) begin
      busy_r    <= 1'b1;
      quo_r     <= SPAN * {32'd0, cur_r};
      rem_r     <= 32'd0;
      iter_r    <= 6'd0;
      pw_next_r <= pw_next_r;
    end else begin
      busy_r    <= 1'b0;
      quo_r     <= quo_r;
      rem_r     <= rem_r;
      iter_r    <= iter_r;
      pw_next_r <= pw_next_r;
    end
  end

  assign pwm_out     = pwm_r;
  assign cur_angle   = cur_r;
  assign at_target   = (cur_r == target_r);
  assign clamped     = clamped_r;
  assign frame_start = frame_start_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_servo_pwm_ramp.sv
// Bench for servo_pwm_ramp: frame-level reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized targets and enables.
module tb_servo_pwm_ramp;

  localparam int unsigned P    = 100;
  localparam int unsigned MINP = 10;
  localparam int unsigned MAXP = 50;
  localparam int unsigned AMAX = 180;
  localparam logic [31:0] STEP = 32'h000A_0000;
  localparam logic [31:0] HOME = 32'h005A_0000;
  localparam logic [31:0] AMAX_Q = 32'h00B4_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] angle_in = 32'd0;
  logic        angle_valid = 1'b0;
  logic        pwm_out;
  logic [31:0] cur_angle;
  logic        at_target;
  logic        clamped;
  logic        frame_start;
  logic        busy;

  int checks = 0;
  int errors = 0;

  servo_pwm_ramp #(
    .PERIOD_CYC(P), .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .ANGLE_MAX(AMAX),
    .STEP(STEP), .HOME(HOME), .HOME_PULSE(30)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .angle_in(angle_in), .angle_valid(angle_valid),
    .pwm_out(pwm_out), .cur_angle(cur_angle), .at_target(at_target), .clamped(clamped),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse width in cycles for a given angle: MIN + span*angle/full-scale, truncated.
  function automatic logic [31:0] pw_of(input logic [31:0] ang);
    longint unsigned num;
    num = longint'(MAXP - MINP) * longint'({32'd0, ang});
    return 32'(longint'(MINP) + num / (longint'(AMAX) * 65536));
  endfunction

  function automatic logic [31:0] step_toward(input logic [31:0] tgt, input logic [31:0] cur);
    longint d;
    d = longint'({32'd0, tgt}) - longint'({32'd0, cur});
    if (d > longint'({32'd0, STEP})) return cur + STEP;
    else if (d < -longint'({32'd0, STEP})) return cur - STEP;
    else return tgt;
  endfunction

  // Reference model state, advanced once per rising edge.
  int unsigned m_cnt = 0;
  logic [31:0] m_target = HOME, m_cur = HOME, m_pwa = 32'd30, m_pwn = 32'd30;
  logic        m_clamped = 1'b0, m_pwm = 1'b0, m_fs = 1'b0, m_busy = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_target = HOME; m_cur = HOME; m_pwa = 32'd30; m_pwn = 32'd30;
      m_clamped = 1'b0; m_pwm = 1'b0; m_fs = 1'b0; m_busy = 1'b0;
    end else begin
      m_pwm  = en && (m_cnt < m_pwa);
      m_fs   = (m_cnt == P - 1);
      m_busy = (m_cnt < 64);
      if (m_cnt == 64) m_pwn = pw_of(m_cur);
      if (m_cnt == P - 1 && en) begin
        m_cur = step_toward(m_target, m_cur);
        m_pwa = m_pwn;
      end
      if (angle_valid) begin
        m_clamped = (angle_in > AMAX_Q);
        m_target  = m_clamped ? AMAX_Q : angle_in;
      end
      m_cnt = (m_cnt + 1) % P;
      #1;
      chk("pwm_out", {31'd0, pwm_out}, {31'd0, m_pwm});
      chk("cur_angle", cur_angle, m_cur);
      chk("at_target", {31'd0, at_target}, {31'd0, m_cur == m_target});
      chk("clamped", {31'd0, clamped}, {31'd0, m_clamped});
      chk("frame_start", {31'd0, frame_start}, {31'd0, m_fs});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
    end
  end

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 3 * P);
    checks++;
    if (!frame_start) begin
      errors++;
      $display("FAIL wait_frame_start: got timeout after %0d cycles required a frame_start pulse", n);
    end
  endtask

  task automatic count_frame(output int h);
    h = 0;
    repeat (P) begin
      @(negedge clk);
      h += int'(pwm_out);
    end
  endtask

  task automatic send(input logic [31:0] a);
    angle_in = a;
    angle_valid = 1'b1;
    @(negedge clk);
    angle_valid = 1'b0;
  endtask

  int h;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
    chk("rst_cur", cur_angle, HOME);
    chk("rst_at_target", {31'd0, at_target}, 32'd1);
    chk("rst_clamped", {31'd0, clamped}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
    rst_n = 1'b1;
    en = 1'b1;

    // Home pulse width
    wait_fs();
    count_frame(h);
    chk("home_pulse", 32'(h), 32'd30);
    chk("home_cur", cur_angle, HOME);

    // Ramp 90 -> 180 in 10-degree steps
    send(32'h00B4_0000);
    repeat (8) wait_fs();
    chk("ramp_8", cur_angle, 32'h00AA_0000);
    chk("ramp_8_not_at", {31'd0, at_target}, 32'd0);
    wait_fs();
    chk("ramp_9", cur_angle, 32'h00B4_0000);
    chk("ramp_9_at", {31'd0, at_target}, 32'd1);
    count_frame(h);
    chk("pulse_170", 32'(h), 32'd47);
    count_frame(h);
    chk("pulse_180", 32'(h), 32'd50);

    // Clamp above full scale, then clear on a legal capture
    send(32'h00C8_0000);
    chk("clamp_set", {31'd0, clamped}, 32'd1);
    chk("clamp_at", {31'd0, at_target}, 32'd1);
    send(32'h0000_0000);
    chk("clamp_clr", {31'd0, clamped}, 32'd0);
    send(HOME);
    repeat (12) wait_fs();
    chk("back_home", cur_angle, HOME);

    // Small move 90 -> 95 and truncated pulse width
    send(32'h005F_0000);
    wait_fs();
    chk("cur_95", cur_angle, 32'h005F_0000);
    count_frame(h);
    chk("pulse_90_lag", 32'(h), 32'd30);
    count_frame(h);
    chk("pulse_95", 32'(h), 32'd31);

    // Capture on the boundary cycle: ramp must use the old target
    repeat (P - 1) @(negedge clk);
    angle_in = 32'd0;
    angle_valid = 1'b1;
    @(negedge clk);
    angle_valid = 1'b0;
    chk("bnd_fs", {31'd0, frame_start}, 32'd1);
    chk("bnd_cur", cur_angle, 32'h005F_0000);
    chk("bnd_not_at", {31'd0, at_target}, 32'd0);

    // Disable mid-pulse, hold across frames, resume with the old width
    wait_fs();
    chk("cur_85", cur_angle, 32'h0055_0000);
    repeat (5) @(negedge clk);
    chk("pre_dis_pwm", {31'd0, pwm_out}, 32'd1);
    en = 1'b0;
    @(negedge clk);
    chk("dis_pwm", {31'd0, pwm_out}, 32'd0);
    repeat (3) wait_fs();
    chk("dis_hold", cur_angle, 32'h0055_0000);
    en = 1'b1;
    count_frame(h);
    chk("resume_pulse", 32'(h), 32'd31);

    // Randomized targets and enable toggles
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      angle_in = $urandom_range(0, 220 * 65536);
      angle_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 199) == 0) en = ~en;
    end
    @(negedge clk);
    angle_valid = 1'b0;
    en = 1'b1;

    // Asynchronous reset mid-ramp
    send(32'h00B4_0000);
    wait_fs();
    wait_fs();
    repeat (5) @(negedge clk);
    chk("pre_rst_pwm", {31'd0, pwm_out}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", {31'd0, pwm_out}, 32'd0);
    chk("async_rst_cur", cur_angle, HOME);
    chk("async_rst_at", {31'd0, at_target}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs();
    count_frame(h);
    chk("post_rst_pulse", 32'(h), 32'd30);
    chk("post_rst_cur", cur_angle, HOME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
